rr_mux: RTL
===========

Name: rr_mux

Overview:
- Sequential counterpart of the parameterised demux: gathers 2**SEL_W input lanes onto one output stream.
- A round-robin arbiter picks the lane; a registered output stage carries the data plus a lane tag `out_sel`.
- `out_sel` can drive a demux `sel` at the far end, so the pair forms a time-division link.
- Valid/ready handshake on every lane and on the output.

Parameters:
- SEL_W, 2, width of the lane index; lane count N = 2**SEL_W.
- DATA_W, 8, width of each lane's payload.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-lane valid; bit i belongs to lane i.
- in_data  input  N*DATA_W  packed payloads; lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  N  per-lane ready; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  registered payload.
- out_sel  output  SEL_W  index of the lane that supplied out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is all-zero while rst is high.
- State: a two-state output stage, EMPTY (out_valid=0) and FULL (out_valid=1), plus rr_ptr (SEL_W bits).
- load_en = !out_valid | out_ready.
- Grant (combinational):
  - When load_en=1 and any in_valid bit is set, grant the first lane with in_valid=1, searching upward from rr_ptr and wrapping past N-1 to 0.
  - in_ready = grant vector; it is 0 when load_en=0.
  - in_ready never depends on in_valid of the granted lane beyond the arbitration itself.
- Transfer on a lane: in_valid[i] & in_ready[i] on a clock edge. On that edge:
  - out_data <= lane i payload, out_sel <= i, out_valid <= 1.
  - rr_ptr <= i+1 mod N; wraps from N-1 to 0.
- Drain: out_valid & out_ready with no new grant -> out_valid <= 0 (FULL->EMPTY). out_data and out_sel keep their last values.
- Simultaneous drain + grant: the new beat loads in the same cycle. out_valid stays 1, giving 1 beat per clock sustained throughput.
- Backpressure:
  - out_valid=1 & out_ready=0 -> out_data, out_sel and out_valid hold stable.
  - in_ready is all-zero and rr_ptr does not move.
- Latency: 1 clock from lane handshake to out_valid.
- No valid lanes: no grant and rr_ptr unchanged. The stage drains normally.
- Fairness: each continuously-valid lane is granted at least once every N grants.
- Reset mid-beat: any held beat is discarded and out_valid drops immediately (asynchronous). After release, arbitration restarts from lane 0.
- in_valid may deassert without a handshake; the design does not require that it stay high.

Decomposition:
- Shared package rr_mux_pkg holds:
  - the lane-count constant/function N = 2**SEL_W;
  - the FULL/EMPTY state encoding.
- One sub-module, rr_arbiter: combinational rotating-priority arbiter.
  - Inputs: req[N], ptr[SEL_W], en.
  - Outputs: grant[N] one-hot, gnt_idx[SEL_W], any.
- rr_mux itself holds rr_ptr, the output register and the packed-payload slice mux.

Test Plan (SEL_W=2, DATA_W=8):
- Reset: rst=1 with random inputs -> out_valid=0, out_data=0x00, out_sel=0, in_ready=4'b0000. After release with in_valid=0, outputs are unchanged.
- Single lane: in_valid=4'b0100, lane2 data 0xA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=0xA5, out_sel=2, rr_ptr=3.
- Round-robin: all lanes valid, lane i data 0x10+i, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 and out_data 0x10..0x13 repeating, out_valid=1 every cycle.
- Backpressure: beat 0x11/sel 1 held with out_ready=0 for 3 cycles -> out_data/out_sel stable and in_ready=0000. On out_ready=1 the next lane (2) loads in the same cycle.
- Wrap/skip: rr_ptr=3, in_valid=4'b0011 -> lane 0 granted first, then lane 1. rr_ptr ends at 2.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid falls immediately, without waiting for a clock edge. After release, first grant goes to the lowest valid lane from 0.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin lane mux: lane count helper and
// the output-stage state encoding.
package rr_mux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    function automatic int lane_count(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester found
// searching upward from ptr, wrapping past the top lane back to lane 0.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int SEL_W = 2,
    localparam int N = lane_count(SEL_W)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // The SEL_W-bit add wraps naturally, so the search order is ptr, ptr+1, ...
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = ptr + SEL_W'(k);
                if (!any && req[idx]) begin
                    any        = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_idx    = idx;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 round-robin lane mux with a registered output stage that carries the
// payload and the index of the lane that supplied it.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    localparam int N = lane_count(SEL_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    out_sel
);

    stage_state_e      state_q, state_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic              load_en;
    logic              arb_en;
    logic [N-1:0]      grant;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any_grant;
    logic [DATA_W-1:0] lane_data;

    assign load_en = (state_q == ST_EMPTY) || out_ready;
    // Gate with rst so no lane sees ready while the stage is held in reset.
    assign arb_en  = load_en && !rst;

    rr_arbiter #(
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .any     (any_grant)
    );

    assign in_ready = grant;

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                lane_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant always implies a handshake, since grants only go to valid lanes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_grant) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !any_grant) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
    end

    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            data_d   = lane_data;
            sel_d    = gnt_idx;
            rr_ptr_d = gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data = data_q;
    assign out_sel  = sel_q;

endmodule
